// File: rtl/vic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vic_pkg
// Brief    : Shared states, defaults and priority helper for the vectored
//            interrupt controller.
// Revision : 1.0
// ============================================================================
package vic_pkg;

    localparam int c_default_num_interrupts = 8;
    localparam int c_default_sync_stages    = 2;
    localparam int c_default_id_width       = 8;
    localparam int c_max_interrupts         = 256;

    typedef enum logic [1:0] {
        VIC_IDLE   = 2'd0,
        VIC_REQ    = 2'd1,
        VIC_ACTIVE = 2'd2
    } vic_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] index;
    } vic_winner_t;

    // Scanning from the top down leaves the lowest set bit as the final answer.
    function automatic vic_winner_t lowest_set_index(input logic [c_max_interrupts-1:0] vector);
        vic_winner_t result;
        result = '0;
        for (int i = c_max_interrupts - 1; i >= 0; i--) begin
            if (vector[i]) begin
                result.valid = 1'b1;
                result.index = 8'(i);
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vic_sync.sv
`default_nettype none
// ============================================================================
// Module   : vic_sync
// Brief    : STAGES-deep, WIDTH-wide flop synchronizer for raw interrupt lines.
// Revision : 1.0
// ============================================================================
module vic_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/vectored_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : vectored_interrupt_controller
// Brief    : N-source prioritised interrupt controller with edge/level pending
//            logic and a REQ/ACTIVE dispatch handshake to the CPU.
// Revision : 1.0
// ============================================================================
module vectored_interrupt_controller
    import vic_pkg::*;
#(
    parameter int NUM_INTERRUPTS = c_default_num_interrupts,
    parameter int SYNC_STAGES    = c_default_sync_stages,
    parameter int ID_WIDTH       = c_default_id_width
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_INTERRUPTS-1:0] interrupts,
    input  logic [NUM_INTERRUPTS-1:0] int_enable,
    input  logic [NUM_INTERRUPTS-1:0] int_level,
    input  logic [NUM_INTERRUPTS-1:0] pending_clr,
    input  logic                      intDisabled,
    output logic                      intCPU,
    output logic [ID_WIDTH-1:0]       intID,
    output logic [NUM_INTERRUPTS-1:0] pending
);

    logic [NUM_INTERRUPTS-1:0] w_sync_out;
    logic [NUM_INTERRUPTS-1:0] r_sync_prev;
    logic [NUM_INTERRUPTS-1:0] r_edge_pending;
    logic [NUM_INTERRUPTS-1:0] w_rise;
    logic [NUM_INTERRUPTS-1:0] w_eligible;
    logic [NUM_INTERRUPTS-1:0] w_take;
    logic [NUM_INTERRUPTS-1:0] w_edge_next;
    vic_winner_t               w_winner;
    logic                      w_dispatch;

    vic_state_t                r_state;
    logic                      r_int_cpu;
    logic [ID_WIDTH-1:0]       r_int_id;

    vic_sync #(
        .WIDTH  (NUM_INTERRUPTS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (interrupts),
        .o_data  (w_sync_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_prev <= '0;
        end else begin
            r_sync_prev <= w_sync_out;
        end
    end

    assign w_rise     = w_sync_out & ~r_sync_prev;
    // Level channels report the registered line directly; edge channels report the latch.
    assign pending    = (int_level & r_sync_prev) | (~int_level & r_edge_pending);
    assign w_eligible = pending & int_enable;
    assign w_winner   = lowest_set_index({{(c_max_interrupts - NUM_INTERRUPTS){1'b0}}, w_eligible});
    assign w_dispatch = (r_state == VIC_IDLE) && !intDisabled && w_winner.valid;

    always_comb begin
        w_take = '0;
        for (int i = 0; i < NUM_INTERRUPTS; i++) begin
            w_take[i] = w_dispatch && (w_winner.index == 8'(i));
        end
    end

    // A fresh rise wins over both software clear and dispatch clear.
    assign w_edge_next = ~int_level & (w_rise | (r_edge_pending & ~pending_clr & ~w_take));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_pending <= '0;
        end else begin
            r_edge_pending <= w_edge_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= VIC_IDLE;
            r_int_cpu <= 1'b0;
            r_int_id  <= '0;
        end else begin
            case (r_state)
                VIC_IDLE: begin
                    if (w_dispatch) begin
                        r_state   <= VIC_REQ;
                        r_int_cpu <= 1'b1;
                        r_int_id  <= ID_WIDTH'({24'd0, w_winner.index} + 32'd1);
                    end
                end
                VIC_REQ: begin
                    if (intDisabled) begin
                        r_state   <= VIC_ACTIVE;
                        r_int_cpu <= 1'b0;
                    end
                end
                VIC_ACTIVE: begin
                    if (!intDisabled) begin
                        r_state <= VIC_IDLE;
                    end
                end
                default: begin
                    r_state   <= VIC_IDLE;
                    r_int_cpu <= 1'b0;
                end
            endcase
        end
    end

    assign intCPU = r_int_cpu;
    assign intID  = r_int_id;

endmodule
`default_nettype wire

// File: tb/tb_vectored_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vectored_interrupt_controller
// Brief    : Directed and randomized self-checking bench with a reference model.
// Revision : 1.0
// ============================================================================
module tb_vectored_interrupt_controller;

    localparam int N   = 16;
    localparam int S   = 2;
    localparam int IDW = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   interrupts;
    logic [N-1:0]   int_enable;
    logic [N-1:0]   int_level;
    logic [N-1:0]   pending_clr;
    logic           intDisabled;
    logic           intCPU;
    logic [IDW-1:0] intID;
    logic [N-1:0]   pending;

    int total = 0;
    int bad   = 0;

    vectored_interrupt_controller #(
        .NUM_INTERRUPTS (N),
        .SYNC_STAGES    (S),
        .ID_WIDTH       (IDW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .interrupts  (interrupts),
        .int_enable  (int_enable),
        .int_level   (int_level),
        .pending_clr (pending_clr),
        .intDisabled (intDisabled),
        .intCPU      (intCPU),
        .intID       (intID),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // Reference model: input history, pending set, and a request/handler flag pair.
    logic [N-1:0]   m_hist [S];
    logic [N-1:0]   m_prev;
    logic [N-1:0]   m_edge;
    logic           m_req;
    logic           m_busy;
    logic [IDW-1:0] m_id;
    logic [N-1:0]   m_pend;
    logic [N-1:0]   mn_edge;
    logic           mn_req;
    logic           mn_busy;
    logic [IDW-1:0] mn_id;
    logic           mn_dispatch;
    int             m_winner;

    always_comb begin
        m_pend = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = int_level[i] ? m_prev[i] : m_edge[i];
        end
        m_winner = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_pend[i] && int_enable[i]) m_winner = i;
        end
        mn_dispatch = !m_req && !m_busy && !intDisabled && (m_winner >= 0);
        mn_edge = m_edge;
        for (int i = 0; i < N; i++) begin
            if (int_level[i])                                        mn_edge[i] = 1'b0;
            else if (m_hist[S-1][i] && !m_prev[i])                   mn_edge[i] = 1'b1;
            else if (pending_clr[i] || (mn_dispatch && m_winner == i)) mn_edge[i] = 1'b0;
        end
        mn_req  = m_req;
        mn_busy = m_busy;
        mn_id   = m_id;
        if (mn_dispatch) begin
            mn_req = 1'b1;
            mn_id  = IDW'(m_winner + 1);
        end else if (m_req && intDisabled) begin
            mn_req  = 1'b0;
            mn_busy = 1'b1;
        end else if (m_busy && !intDisabled) begin
            mn_busy = 1'b0;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < S; i++) m_hist[i] <= '0;
            m_prev <= '0;
            m_edge <= '0;
            m_req  <= 1'b0;
            m_busy <= 1'b0;
            m_id   <= '0;
        end else begin
            m_hist[0] <= interrupts;
            for (int i = 1; i < S; i++) m_hist[i] <= m_hist[i-1];
            m_prev <= m_hist[S-1];
            m_edge <= mn_edge;
            m_req  <= mn_req;
            m_busy <= mn_busy;
            m_id   <= mn_id;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (intCPU === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            interrupts  = N'($urandom);
            pending_clr = N'($urandom);
            intDisabled = 1'($urandom);
            @(negedge clk);
            total++;
            if (intCPU !== 1'b0 || intID !== '0 || pending !== '0) begin
                bad++;
                $display("FAIL reset_hold: intCPU=%b intID=%0d pending=%h, need 0/0/0", intCPU, intID, pending);
            end
        end
        interrupts  = '0;
        pending_clr = '0;
        intDisabled = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_single_edge();
        interrupts[3] = 1'b1;
        tick(3);
        total++;
        if (pending[3] !== 1'b1 || intCPU !== 1'b0) begin
            bad++;
            $display("FAIL single_pending: pending[3]=%b intCPU=%b, need 1/0", pending[3], intCPU);
        end
        tick(1);
        total++;
        if (intCPU !== 1'b1 || intID !== 8'd4) begin
            bad++;
            $display("FAIL single_req: intCPU=%b intID=%0d, need 1/4", intCPU, intID);
        end
        intDisabled = 1'b1;
        tick(1);
        total++;
        if (intCPU !== 1'b0 || pending[3] !== 1'b0) begin
            bad++;
            $display("FAIL single_accept: intCPU=%b pending[3]=%b, need 0/0", intCPU, pending[3]);
        end
        interrupts[3] = 1'b0;
        tick(2);
        intDisabled = 1'b0;
        tick(4);
    endtask

    task automatic test_simultaneous();
        logic [IDW-1:0] exp_id [3];
        bit ok;
        exp_id[0] = 8'd2; exp_id[1] = 8'd6; exp_id[2] = 8'd7;
        interrupts = 16'h0062;
        for (int k = 0; k < 3; k++) begin
            wait_req(12, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL simul_timeout: dispatch %0d intCPU=%b, need 1", k, intCPU);
            end else if (intID !== exp_id[k]) begin
                bad++;
                $display("FAIL simul_id: dispatch %0d intID=%0d, need %0d", k, intID, exp_id[k]);
            end
            if (k == 0) begin
                total++;
                if (pending !== 16'h0060) begin
                    bad++;
                    $display("FAIL simul_pending: pending=%h, need 0060", pending);
                end
                interrupts = '0;
            end
            intDisabled = 1'b1;
            tick(1);
            total++;
            if (intCPU !== 1'b0) begin
                bad++;
                $display("FAIL simul_accept: intCPU=%b, need 0", intCPU);
            end
            intDisabled = 1'b0;
        end
        tick(6);
        total++;
        if (intCPU !== 1'b0 || pending !== '0) begin
            bad++;
            $display("FAIL simul_drain: intCPU=%b pending=%h, need 0/0", intCPU, pending);
        end
    endtask

    task automatic test_masking();
        bit ok;
        int_enable[0] = 1'b0;
        interrupts[0] = 1'b1;
        tick(4);
        interrupts[0] = 1'b0;
        tick(3);
        total++;
        if (pending[0] !== 1'b1 || intCPU !== 1'b0) begin
            bad++;
            $display("FAIL mask_latched: pending[0]=%b intCPU=%b, need 1/0", pending[0], intCPU);
        end
        int_enable[0] = 1'b1;
        tick(1);
        total++;
        if (intCPU !== 1'b1 || intID !== 8'd1) begin
            bad++;
            $display("FAIL mask_enable: intCPU=%b intID=%0d, need 1/1", intCPU, intID);
        end
        // Dropping the enable during REQ keeps the request alive.
        int_enable[0] = 1'b0;
        tick(2);
        total++;
        if (intCPU !== 1'b1 || intID !== 8'd1) begin
            bad++;
            $display("FAIL mask_req_hold: intCPU=%b intID=%0d, need 1/1", intCPU, intID);
        end
        intDisabled = 1'b1;
        tick(1);
        intDisabled = 1'b0;
        tick(3);
        interrupts[0] = 1'b1;
        tick(4);
        interrupts[0] = 1'b0;
        tick(3);
        pending_clr[0] = 1'b1;
        tick(1);
        pending_clr[0] = 1'b0;
        total++;
        if (pending[0] !== 1'b0) begin
            bad++;
            $display("FAIL mask_clr: pending[0]=%b, need 0", pending[0]);
        end
        int_enable[0] = 1'b1;
        wait_req(6, ok);
        total++;
        if (ok) begin
            bad++;
            $display("FAIL mask_no_dispatch: intCPU=%b intID=%0d, need intCPU 0", intCPU, intID);
        end
    endtask

    task automatic test_level();
        bit ok;
        int_level[2]  = 1'b1;
        interrupts[2] = 1'b1;
        wait_req(10, ok);
        total++;
        if (!ok || intID !== 8'd3) begin
            bad++;
            $display("FAIL level_first: intCPU=%b intID=%0d, need 1/3", intCPU, intID);
        end
        intDisabled = 1'b1;
        tick(2);
        total++;
        if (intCPU !== 1'b0 || pending[2] !== 1'b1) begin
            bad++;
            $display("FAIL level_active: intCPU=%b pending[2]=%b, need 0/1", intCPU, pending[2]);
        end
        intDisabled = 1'b0;
        wait_req(4, ok);
        total++;
        if (!ok || intID !== 8'd3) begin
            bad++;
            $display("FAIL level_redispatch: intCPU=%b intID=%0d, need 1/3", intCPU, intID);
        end
        intDisabled = 1'b1;
        tick(1);
        interrupts[2] = 1'b0;
        tick(4);
        intDisabled = 1'b0;
        wait_req(6, ok);
        total++;
        if (ok) begin
            bad++;
            $display("FAIL level_dropped: intCPU=%b, need 0", intCPU);
        end
        int_level[2] = 1'b0;
        tick(2);
    endtask

    task automatic test_race_and_wide();
        bit ok;
        interrupts[4] = 1'b1;
        tick(2);
        pending_clr[4] = 1'b1;
        tick(1);
        pending_clr[4] = 1'b0;
        total++;
        if (pending[4] !== 1'b1) begin
            bad++;
            $display("FAIL race_set_wins: pending[4]=%b, need 1", pending[4]);
        end
        tick(1);
        total++;
        if (intCPU !== 1'b1 || intID !== 8'd5) begin
            bad++;
            $display("FAIL race_dispatch: intCPU=%b intID=%0d, need 1/5", intCPU, intID);
        end
        intDisabled = 1'b1;
        interrupts[4] = 1'b0;
        tick(2);
        intDisabled = 1'b0;
        tick(3);
        interrupts[15] = 1'b1;
        wait_req(10, ok);
        total++;
        if (!ok || intID !== 8'd16) begin
            bad++;
            $display("FAIL wide_id16: intCPU=%b intID=%0d, need 1/16", intCPU, intID);
        end
        intDisabled = 1'b1;
        interrupts[15] = 1'b0;
        tick(2);
        intDisabled = 1'b0;
        tick(3);
    endtask

    task automatic test_midop_reset();
        bit ok;
        interrupts[7] = 1'b1;
        wait_req(10, ok);
        interrupts[9] = 1'b1;
        tick(4);
        total++;
        if (!ok || pending[9] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_setup: req=%b pending[9]=%b, need 1/1", ok, pending[9]);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (intCPU !== 1'b0 || intID !== '0 || pending !== '0) begin
            bad++;
            $display("FAIL midrst_async: intCPU=%b intID=%0d pending=%h, need 0/0/0", intCPU, intID, pending);
        end
        interrupts = '0;
        tick(2);
        reset_n = 1'b1;
        wait_req(8, ok);
        total++;
        if (ok) begin
            bad++;
            $display("FAIL midrst_discard: intCPU=%b intID=%0d, need intCPU 0", intCPU, intID);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            total++;
            if (intCPU !== m_req) begin
                bad++;
                $display("FAIL rand_intcpu: cycle %0d got %b, need %b", c, intCPU, m_req);
            end
            total++;
            if (intID !== m_id) begin
                bad++;
                $display("FAIL rand_intid: cycle %0d got %0d, need %0d", c, intID, m_id);
            end
            total++;
            if (pending !== m_pend) begin
                bad++;
                $display("FAIL rand_pending: cycle %0d got %h, need %h", c, pending, m_pend);
            end
            interrupts  = interrupts ^ (N'($urandom) & N'($urandom) & N'($urandom));
            pending_clr = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
            if ($urandom_range(0, 63) == 0)  int_enable = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 255) == 0) int_level  = N'($urandom) & N'($urandom);
            if (intCPU && !intDisabled && $urandom_range(0, 2) == 0) intDisabled = 1'b1;
            else if (intDisabled && $urandom_range(0, 4) == 0)       intDisabled = 1'b0;
        end
        interrupts  = '0;
        pending_clr = '0;
        int_level   = '0;
        int_enable  = '1;
        intDisabled = 1'b0;
        tick(10);
    endtask

    initial begin
        reset_n     = 1'b0;
        interrupts  = '0;
        int_enable  = '1;
        int_level   = '0;
        pending_clr = '0;
        intDisabled = 1'b0;
        test_reset();
        test_single_edge();
        test_simultaneous();
        test_masking();
        test_level();
        test_race_and_wide();
        test_midop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vectored_interrupt_controller.md
# vectored_interrupt_controller

Parametrised successor to the fixed 8-channel CPU interrupt controller: N asynchronous interrupt sources, per-channel enable mask and edge/level mode, software-visible pending vector, and a three-state dispatch handshake with the CPU. Sits between the peripheral interrupt lines and the CPU core. It also feeds the MMIO register block that owns the enable, mode and clear registers. Lowest index has highest priority; IDs start at 1.

## Interface
- NUM_INTERRUPTS, 8: number of sources, legal range 1..255.
- SYNC_STAGES, 2: synchronizer depth per input, legal range ≥2.
- ID_WIDTH, 8: width of intID; must satisfy 2^ID_WIDTH > NUM_INTERRUPTS.
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- interrupts  in  NUM_INTERRUPTS  raw async sources; bit i is ID i+1.
- int_enable  in  NUM_INTERRUPTS  1 = channel may dispatch; quasi-static, driven from MMIO.
- int_level  in  NUM_INTERRUPTS  1 = level-sensitive, 0 = rising-edge.
- pending_clr  in  NUM_INTERRUPTS  one-cycle pulse per bit; clears the edge-mode pending bit.
- intDisabled  in  1  CPU interrupt-disable flag; high while a handler runs.
- intCPU  out  1  interrupt request to the CPU.
- intID  out  ID_WIDTH  ID of the request; 0 when none has been dispatched since reset.
- pending  out  NUM_INTERRUPTS  raw pending vector, before masking, for MMIO readback.

## Operation
- Each input passes through SYNC_STAGES flops; sync_out is the last stage.
- Edge-mode pending bit:
  - Set on a sync_out 0→1 transition, against a registered previous value.
  - Cleared by dispatch of that channel or by pending_clr.
  - Set wins over clear in the same cycle.
  - Latches even while int_enable is low.
- Level-mode pending bit:
  - Equals registered sync_out.
  - Not cleared by dispatch; pending_clr has no effect.
  - The source must drop before reti, or the channel re-dispatches.
- Eligible vector = pending & int_enable. Winner = lowest set index (generic priority encoder, no unrolled chain).
- FSM states:
  - IDLE: if !intDisabled and eligible ≠ 0, latch intID = winner+1, clear the winner's edge pending bit, go to REQ. Otherwise stay.
  - REQ: intCPU = 1 and intID stable. When intDisabled = 1 (CPU accepted), go to ACTIVE.
  - ACTIVE: intCPU = 0. When intDisabled = 0 (reti), go to IDLE.
- There is no REQ timeout; REQ holds until the CPU accepts.
- Masking: int_enable dropping while in REQ does not withdraw the request.
- intID holds its last value in IDLE and ACTIVE.
- Multiple simultaneous edges: all latch. They dispatch one per handler, in priority order.
- Repeat edge on a channel already pending: merged; no count is kept.

## Timing
- Reset (async assert, sync deassert upstream):
  - intCPU = 0, intID = 0, pending = 0.
  - Synchronizers, prev register and FSM cleared; FSM = IDLE.
  - Mid-operation reset drops intCPU immediately and discards all pending state.
- Latency, edge mode: input rises before clk edge k → sync_out high after edge k+SYNC_STAGES-1 → pending high after k+SYNC_STAGES → intCPU high after k+SYNC_STAGES+1. With SYNC_STAGES = 2 this is 4 clocks, provided the FSM is in IDLE and intDisabled = 0.
- Latency, level mode: identical to edge mode.
- intCPU falls on the clock after intDisabled is first sampled high in REQ.
- IDLE re-entry occurs on the clock after intDisabled is sampled low in ACTIVE. The next dispatch can assert intCPU one clock later.
- Minimum input pulse width for edge capture: SYNC_STAGES+1 clocks high.
- pending_clr takes effect on the following clock.
- pending readback lags the FSM's clear by 0 cycles: both update on the same edge.

## Structure
- Package vic_pkg holds:
  - FSM state constants VIC_IDLE = 2'd0, VIC_REQ = 2'd1, VIC_ACTIVE = 2'd2.
  - Default parameter constants.
  - A function lowest_set_index(vector) returning the index plus a valid flag.
- One sub-module: vic_sync, a parametrised SYNC_STAGES-deep, WIDTH-wide synchronizer on clk/reset_n. Instantiate it once for the whole vector.
- Priority encoder, pending logic and FSM stay in vectored_interrupt_controller.

## Test plan
- Reset: hold reset_n low and toggle inputs → intCPU = 0, intID = 0, pending = 0. Assert reset_n low while in REQ → intCPU drops with no clock edge.
- Single edge: ch 3 (edge mode, enabled) 0→1 at edge 0 → intCPU high after edge 4 with intID = 4. intDisabled high → intCPU low on the next clock, pending[3] = 0.
- Simultaneous edges: ch 5, 1 and 6 rise together → dispatch IDs 2, 6, 7 in order across three handler cycles. pending = 0x60 after the first dispatch.
- Masking: ch 0 disabled and pulsed → pending[0] = 1, no intCPU. Enable ch 0 → intCPU with intID = 1. Repeat with pending_clr[0] before enabling → no dispatch.
- Level mode: ch 2 level-sensitive held high through reti → second dispatch with intID = 3. Source dropped before reti → no second dispatch.
- Set/clear race: pending_clr[4] in the same cycle as ch 4's edge is registered → pending[4] = 1. Also, with NUM_INTERRUPTS = 16, ch 15 → intID = 16.
